// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, waits
// LATENCY busy cycles, then commits the store or returns the load word with a one-cycle strobe.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        err_misaligned,
  output logic        stall
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          write_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          commit;

  assign commit = (state == BUSY) && (cnt == '0);
  assign stall  = req_valid & ~resp_valid;

  // Upper address bits are deliberately dropped so addresses wrap modulo the array.
  generate
    if (2 + IW < 32) begin : g_wrap
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[31:2+IW];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      write_q        <= 1'b0;
      idx_q          <= '0;
      wdata_q        <= '0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      err_misaligned <= 1'b0;
    end else begin
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      err_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            idx_q     <= req_addr[2 +: IW];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_addr[1:0] != 2'b00) begin
              state          <= RESP;
              resp_valid     <= 1'b1;
              err_misaligned <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= LAT_M1;
            end
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            if (!write_q) resp_rdata <= mem[idx_q];
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Gated by reset so a store interrupted by reset is never committed.
  always_ff @(posedge clk) begin
    if (!reset && commit && write_q) mem[idx_q] <= wdata_q;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder on the far side of the CPU's load/store interface. The memory pipeline stage issues one load or store at a time. This block accepts it, waits a configurable access latency, and commits the write or returns the read word with a one-cycle response strobe. While an access is outstanding it drives `stall` so the pipeline holds.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the backing array; power of two, at least 2.
- LATENCY, 2: BUSY cycles per aligned access; at least 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  the memory stage has a load or store pending.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_ready  out  1  the block can accept a request this cycle.
- resp_valid  out  1  one-cycle completion strobe.
- resp_rdata  out  32  load data; 0 for stores and errors.
- err_misaligned  out  1  valid only with resp_valid; set when req_addr[1:0] != 0.
- stall  out  1  holds the upstream pipeline.

## Operation
- States: IDLE, BUSY, RESP. A down-counter of width clog2(LATENCY)+1 tracks the BUSY cycles.
- IDLE:
  - req_ready = 1.
  - The request is accepted when req_valid & req_ready.
  - At acceptance, register req_write, req_addr and req_wdata. Later changes on the request inputs are ignored.
  - Accepted aligned request: go to BUSY with the counter loaded to LATENCY-1.
  - Accepted misaligned request: go directly to RESP with the error flag set. No array access takes place.
- BUSY:
  - req_ready = 0.
  - If the counter is nonzero, decrement it.
  - If the counter is 0:
    - Store: write the array word at index addr[2 +: clog2(DEPTH_WORDS)].
    - Load: register the array word into resp_rdata.
    - Go to RESP.
- RESP:
  - resp_valid = 1 for exactly this cycle. req_ready = 0.
  - Then go unconditionally to IDLE.
  - A req_valid still high during RESP is not accepted.
- stall = req_valid & ~resp_valid. As a result:
  - stall is 1 in the acceptance cycle and every BUSY cycle.
  - stall is 0 in RESP, which lets the pipeline advance.
  - stall is 0 whenever req_valid is low.
- Addressing:
  - Address bits above the index width are ignored, so out-of-range addresses wrap modulo DEPTH_WORDS.
  - Bits [1:0] are used only for the misalignment check.
- resp_rdata is 0 and err_misaligned is 0 in every cycle where resp_valid is 0. On a store response, resp_rdata is 0.
- Reset:
  - Returns to IDLE with the counter at 0.
  - Outputs are cleared to resp_valid=0, resp_rdata=0, err_misaligned=0, req_ready=1.
  - stall then follows req_valid.
  - A store still in BUSY when reset asserts is dropped and never written.
  - Array contents are not cleared by reset. Contents at power-up are undefined.

## Timing
- Aligned access:
  - Accepted in cycle 0.
  - BUSY in cycles 1..LATENCY.
  - The array write or read occurs at the edge that ends cycle LATENCY.
  - resp_valid is high in cycle LATENCY+1.
  - IDLE again in cycle LATENCY+2.
- Misaligned access: accepted in cycle 0, resp_valid with err_misaligned=1 in cycle 1, IDLE in cycle 2.
- Peak throughput is one aligned access per LATENCY+2 cycles. There is no overlap of requests.
- A load issued to the same word after a store response returns the newly stored data.
- Back-to-back request with req_valid held through RESP: the next request is accepted in the IDLE cycle that immediately follows RESP.

## Test plan
- Reset, LATENCY=2:
  - Stimulus: assert reset for 2 cycles with req_valid=0.
  - Required: req_ready=1, resp_valid=0, resp_rdata=0, stall=0.
  - Then raise req_valid: stall=1 in the same cycle.
- Store then load:
  - Stimulus: store 0xDEADBEEF to address 0x10, accepted in cycle 0.
  - Required for the store: stall=1 in cycles 0-2; resp_valid=1 with rdata=0 in cycle 3.
  - Stimulus: load 0x10, accepted in cycle 4.
  - Required for the load: resp_valid=1 with resp_rdata=0xDEADBEEF in cycle 7.
- Misaligned:
  - Stimulus: load 0x13.
  - Required: resp_valid=1, err_misaligned=1, rdata=0 in the cycle after acceptance.
  - Follow-up: a later aligned load of 0x10 still returns the previously stored word, confirming no array access occurred.
- Wrap:
  - Stimulus: with DEPTH_WORDS=256, store 0x12345678 to 0x400, then load 0x0.
  - Required: the load returns 0x12345678.
- Held request:
  - Stimulus: hold req_valid=1 continuously with constant fields.
  - Required: exactly one acceptance per 4 cycles (LATENCY=2); req_ready=0 during RESP; stall low only in RESP cycles.
- Reset mid-store:
  - Stimulus: store 0xAAAA5555 to 0x20 (initialised earlier to 0x11111111); assert reset in cycle 1 (BUSY).
  - Required: no resp_valid.
  - Follow-up: a subsequent load of 0x20 returns 0x11111111.
